mem_stage: RTL and testbench
============================

// Module: mem_stage
// PURPOSE
//  Memory-access pipeline stage between EXE and WB of the 5-stage LoongArch core.
//  Collects the data-SRAM response for loads/stores issued in EXE, performs load byte/half
//  extraction and sign/zero extension, and forwards the result to WB.
//  Exports a forwarding/hazard bus to ID; drops responses belonging to instructions killed by a WB flush.
// PARAMETERS
//  ES_BUS_W   176  width of es_to_ms_bus (fixed by EXE stage layout)
//  WS_BUS_W   168  width of ms_to_ws_bus (fixed by WB stage layout)
//  FWD_BUS_W   40  width of ms_fwd_bus (fixed by ID bypass logic)
// PORTS
//  clk               in   1    core clock
//  reset             in   1    synchronous, active-high reset
//  es_to_ms_valid    in   1    EXE holds a valid instruction for MEM
//  es_to_ms_bus      in   176  {req_sent,ld_op[4:0],addr_lo[1:0],rj_value,rkd_value,csr_data[33:0],gr_we,dest[4:0],alu_result,pc}
//  ms_allowin        out  1    MEM can accept an instruction this cycle
//  ws_allowin        in   1    WB can accept
//  ms_to_ws_valid    out  1    MEM presents a completed instruction to WB
//  ms_to_ws_bus      out  168  {rj_value,rkd_value,csr_data,gr_we,dest,final_result,pc}
//  data_sram_data_ok in   1    one-cycle response strobe for an outstanding request (load or store)
//  data_sram_rdata   in   32   load data, valid with data_ok
//  wb_ex             in   1    WB exception flush
//  wb_ertn           in   1    WB ertn flush
//  ms_fwd_bus        out  40   {ms_valid,ms_rf_we,ms_dest,ms_fwd_data,ms_fwd_blk}
// BEHAVIOUR
//  - ld_op one-hot {ld_b,ld_h,ld_w,ld_bu,ld_hu}; ld_op==0 & req_sent==1 => store (waits write ack);
//    req_sent==0 => no memory access, ready immediately.
//  - Registers: ms_valid, ms_bus_r, data_buf[31:0], data_got, cancel_cnt[1:0]. Reset: all 0 =>
//    ms_to_ws_valid=0, ms_allowin=1, ms_fwd_bus=0.
//  - Handshake: ms_ready_go = !req_sent_r | data_got | (data_sram_data_ok & cancel_cnt==0);
//    ms_allowin = !ms_valid | (ms_ready_go & ws_allowin); ms_to_ws_valid = ms_valid & ms_ready_go.
//  - Accept: ms_allowin & es_to_ms_valid & !flush => ms_bus_r<=es_to_ms_bus, data_got<=0.
//    ms_valid<=es_to_ms_valid when ms_allowin; flush (wb_ex|wb_ertn) clears ms_valid, highest priority.
//  - Response steering: data_ok with cancel_cnt!=0 is consumed silently, cancel_cnt-=1; otherwise it
//    belongs to the MEM instruction. If data_ok arrives but ws_allowin=0, latch rdata in data_buf,
//    set data_got; data used = data_got ? data_buf : data_sram_rdata.
//  - Flush accounting (same cycle as flush): cancel_cnt += w + e, saturating at 3, where
//    w = ms_valid & req_sent_r & !data_got & !(data_ok & cancel_cnt==0), e = es_to_ms_valid & es req_sent.
//    Simultaneous data_ok consumed by cancel and new cancels: net = cnt - 1 + w + e.
//  - Load extract: byte = rdata[8*addr_lo +: 8]; half = rdata[16*addr_lo[1] +: 16];
//    ld_b/ld_h sign-extend, ld_bu/ld_hu zero-extend, ld_w full word. Misaligned addr is the EXE stage's concern.
//  - final_result = |ld_op ? load_value : alu_result; all other fields pass through unchanged.
//  - Forward: ms_fwd_data = final_result; ms_rf_we = gr_we & ms_valid;
//    ms_fwd_blk = ms_valid & ((|ld_op & !ms_ready_go) | csrrd | csrwr | csrxchg) (csr value only known in WB).
//  - Latency: non-memory op 1 cycle; load/store 1 cycle after data_ok (0 extra if data_ok in entry cycle).
//  - Reset mid-wait: all state cleared, cancel_cnt=0; the memory side is reset simultaneously.
// TESTING
//  - ld.b addr_lo=3, rdata=0x80FF_1234, data_ok in entry cycle -> final_result=0xFFFF_FF80, 1-cycle stage.
//  - ld.hu addr_lo=2, rdata=0xBEEF_0000, data_ok 3 cycles late -> ms_to_ws_valid only on data_ok cycle,
//    final_result=0x0000_BEEF, ms_fwd_blk=1 while waiting.
//  - ws_allowin=0 when data_ok for ld.w 0x1234_5678 -> data_buf holds; ws_allowin=1 two cycles later
//    -> 0x1234_5678 delivered, no second data_ok needed.
//  - wb_ex while MEM load waits and EXE holds req_sent load -> ms_valid=0, cancel_cnt=2; next two
//    data_ok dropped, third data_ok completes newly accepted load.
//  - add (req_sent=0) back-to-back with ws_allowin=1 -> one instruction per cycle, result=alu_result.
//  - reset asserted with cancel_cnt=1 -> ms_valid=0, cancel_cnt=0, ms_fwd_bus=0 next cycle.

Source files
------------

// File: rtl/mem_stage.sv
// ---------------------------------------------------------------------------
// mem_stage
//   Memory-access stage of the 5-stage LoongArch pipeline, between EXE and WB.
//   Waits for the data-SRAM response of the load/store issued in EXE. Loads
//   get byte/half extraction and sign/zero extension. The finished
//   instruction is handed to WB. A forwarding/hazard bus is exported to ID.
//   Responses that belong to instructions killed by a WB flush are dropped.
//
// Ports
//   clk, reset          core clock, synchronous active-high reset
//   es_to_ms_valid/bus  instruction offered by EXE
//                       bus = {req_sent, ld_op[4:0], addr_lo[1:0], rj_value,
//                              rkd_value, csr_data[33:0], gr_we, dest[4:0],
//                              alu_result, pc}
//                       ld_op one-hot = {ld_b, ld_h, ld_w, ld_bu, ld_hu}
//                       csr_data[33:31] = {csrrd, csrwr, csrxchg}
//   ms_allowin          MEM can take a new instruction this cycle
//   ws_allowin          WB can take an instruction this cycle
//   ms_to_ws_valid/bus  completed instruction for WB
//                       bus = {rj_value, rkd_value, csr_data, gr_we, dest,
//                              final_result, pc}
//   data_sram_data_ok   response strobe for an outstanding request
//   data_sram_rdata     load data, valid with data_ok
//   wb_ex, wb_ertn      flush requests from WB
//   ms_fwd_bus          {ms_valid, ms_rf_we, ms_dest, ms_fwd_data, ms_fwd_blk}
// ---------------------------------------------------------------------------
module mem_stage #(
  parameter int ES_BUS_W  = 176,
  parameter int WS_BUS_W  = 168,
  parameter int FWD_BUS_W = 40
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 es_to_ms_valid,
  input  logic [ES_BUS_W-1:0]  es_to_ms_bus,
  output logic                 ms_allowin,
  input  logic                 ws_allowin,
  output logic                 ms_to_ws_valid,
  output logic [WS_BUS_W-1:0]  ms_to_ws_bus,
  input  logic                 data_sram_data_ok,
  input  logic [31:0]          data_sram_rdata,
  input  logic                 wb_ex,
  input  logic                 wb_ertn,
  output logic [FWD_BUS_W-1:0] ms_fwd_bus
);

  // State registers and their next-state values
  logic                msValid_q,   msValid_d;
  logic [ES_BUS_W-1:0] msBus_q,     msBus_d;
  logic [31:0]         dataBuf_q,   dataBuf_d;
  logic                dataGot_q,   dataGot_d;
  logic [1:0]          cancelCnt_q, cancelCnt_d;

  // Fields of the latched EXE bus
  logic        reqSentR;
  logic [4:0]  ldOpR;
  logic [1:0]  addrLoR;
  logic [31:0] rjValueR;
  logic [31:0] rkdValueR;
  logic [33:0] csrDataR;
  logic        grWeR;
  logic [4:0]  destR;
  logic [31:0] aluResultR;
  logic [31:0] pcR;

  assign {reqSentR, ldOpR, addrLoR, rjValueR, rkdValueR, csrDataR,
          grWeR, destR, aluResultR, pcR} = msBus_q;

  // Internal control signals
  logic        flush;
  logic        esReqSent;
  logic        dataOkMine;
  logic        dropResp;
  logic        msReadyGo;
  logic        accept;
  logic        captureResp;
  logic        waitPending;
  logic        exePending;
  logic [2:0]  cancelSum;
  logic [31:0] loadWord;
  logic [7:0]  loadByte;
  logic [15:0] loadHalf;
  logic [31:0] loadValue;
  logic [31:0] finalResult;
  logic        csrAccess;
  logic        fwdBlk;

  assign flush     = wb_ex | wb_ertn;
  assign esReqSent = es_to_ms_bus[ES_BUS_W-1];

  // While cancel_cnt is non-zero, the SRAM still owes responses to killed
  // instructions. Those responses come first because the SRAM answers in
  // order, so they must not be mistaken for the current instruction's data.
  assign dropResp   = data_sram_data_ok & (cancelCnt_q != 2'd0);
  assign dataOkMine = data_sram_data_ok & (cancelCnt_q == 2'd0);

  // Handshake
  assign msReadyGo      = ~reqSentR | dataGot_q | dataOkMine;
  assign ms_allowin     = ~msValid_q | (msReadyGo & ws_allowin);
  assign ms_to_ws_valid = msValid_q & msReadyGo;
  assign accept         = ms_allowin & es_to_ms_valid & ~flush;

  // The response came but WB is stalled, so keep the data until WB is free.
  assign captureResp = msValid_q & reqSentR & ~dataGot_q & dataOkMine & ~ws_allowin;

  // Requests that become orphans on a flush: the MEM one if its answer has
  // not arrived (and is not arriving now), plus the one EXE already sent.
  assign waitPending = msValid_q & reqSentR & ~dataGot_q & ~dataOkMine;
  assign exePending  = es_to_ms_valid & esReqSent;
  assign cancelSum   = {1'b0, cancelCnt_q} + {2'b00, waitPending}
                     + {2'b00, exePending} - {2'b00, dropResp};

  // Next-state logic for the valid bit, payload and response buffer
  always_comb begin
    msValid_d = msValid_q;
    msBus_d   = msBus_q;
    dataGot_d = dataGot_q;
    dataBuf_d = dataBuf_q;
    if (flush) begin
      msValid_d = 1'b0;
    end else if (ms_allowin) begin
      msValid_d = es_to_ms_valid;
    end
    if (accept) begin
      msBus_d   = es_to_ms_bus;
      dataGot_d = 1'b0;
    end else if (captureResp) begin
      dataGot_d = 1'b1;
      dataBuf_d = data_sram_rdata;
    end
  end

  // Next-state logic for the count of responses still to be discarded.
  // On a flush, a response dropped in that same cycle and the new orphans
  // are accounted together; the count saturates at 3.
  always_comb begin
    cancelCnt_d = cancelCnt_q - {1'b0, dropResp};
    if (flush) begin
      if (cancelSum > 3'd3) begin
        cancelCnt_d = 2'd3;
      end else begin
        cancelCnt_d = cancelSum[1:0];
      end
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    if (reset) begin
      msValid_q   <= 1'b0;
      msBus_q     <= '0;
      dataBuf_q   <= '0;
      dataGot_q   <= 1'b0;
      cancelCnt_q <= 2'd0;
    end else begin
      msValid_q   <= msValid_d;
      msBus_q     <= msBus_d;
      dataBuf_q   <= dataBuf_d;
      dataGot_q   <= dataGot_d;
      cancelCnt_q <= cancelCnt_d;
    end
  end

  // Load data selection and extension. Misaligned addresses are rejected
  // earlier in EXE, so addr_lo only selects the lane here.
  assign loadWord = dataGot_q ? dataBuf_q : data_sram_rdata;
  assign loadHalf = addrLoR[1] ? loadWord[31:16] : loadWord[15:0];

  always_comb begin
    loadByte = loadWord[7:0];
    case (addrLoR)
      2'd1:    loadByte = loadWord[15:8];
      2'd2:    loadByte = loadWord[23:16];
      2'd3:    loadByte = loadWord[31:24];
      default: loadByte = loadWord[7:0];
    endcase
  end

  always_comb begin
    loadValue = 32'd0;
    if (ldOpR[4]) begin
      loadValue = {{24{loadByte[7]}}, loadByte};
    end else if (ldOpR[3]) begin
      loadValue = {{16{loadHalf[15]}}, loadHalf};
    end else if (ldOpR[2]) begin
      loadValue = loadWord;
    end else if (ldOpR[1]) begin
      loadValue = {24'd0, loadByte};
    end else if (ldOpR[0]) begin
      loadValue = {16'd0, loadHalf};
    end
  end

  assign finalResult = (|ldOpR) ? loadValue : aluResultR;

  assign ms_to_ws_bus = {rjValueR, rkdValueR, csrDataR, grWeR, destR, finalResult, pcR};

  // ID must stall on a load still waiting for data, and on any CSR
  // instruction, whose value is only known once it reaches WB.
  assign csrAccess  = csrDataR[33] | csrDataR[32] | csrDataR[31];
  assign fwdBlk     = msValid_q & (((|ldOpR) & ~msReadyGo) | csrAccess);
  assign ms_fwd_bus = {msValid_q, grWeR & msValid_q, destR, finalResult, fwdBlk};

endmodule

// File: tb/tb_mem_stage.sv
// ---------------------------------------------------------------------------
// tb_mem_stage
//   Self-checking bench for mem_stage. A transaction-level model tracks the
//   instruction in EXE, the instruction in MEM and an in-order queue of
//   outstanding SRAM requests, each marked live or killed. Expected outputs
//   are derived from that model every cycle.
// ---------------------------------------------------------------------------
module tb_mem_stage;

  typedef struct {
    bit          reqSent;
    logic [4:0]  ldOp;
    logic [1:0]  addrLo;
    logic [31:0] rj;
    logic [31:0] rkd;
    logic [33:0] csr;
    bit          grWe;
    logic [4:0]  dest;
    logic [31:0] alu;
    logic [31:0] pc;
    int          tag;
  } instr_t;

  typedef struct {
    int id;
    bit killed;
  } req_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          esValid;
  logic [175:0]  esBus;
  logic          msAllowin;
  logic          wsAllowin;
  logic          msToWsValid;
  logic [167:0]  msToWsBus;
  logic          dataOk;
  logic [31:0]   rdata;
  logic          wbEx;
  logic          wbErtn;
  logic [39:0]   fwdBus;

  int testCount = 0;
  int failCount = 0;

  // Model state
  instr_t exeInstr, memInstr, idle;
  bit     exeValid, memValid, memHasData;
  logic [31:0] memData;
  req_t   reqQ[$];
  int     nextTag = 1;

  // Expectations of the current cycle
  bit          expValid, expAllowin, expReady;
  logic [31:0] expFinal;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk              (clk),
    .reset            (reset),
    .es_to_ms_valid   (esValid),
    .es_to_ms_bus     (esBus),
    .ms_allowin       (msAllowin),
    .ws_allowin       (wsAllowin),
    .ms_to_ws_valid   (msToWsValid),
    .ms_to_ws_bus     (msToWsBus),
    .data_sram_data_ok(dataOk),
    .data_sram_rdata  (rdata),
    .wb_ex            (wbEx),
    .wb_ertn          (wbErtn),
    .ms_fwd_bus       (fwdBus)
  );

  // Single comparison point used by every check
  task automatic check(input string tag, input logic [167:0] obs, input logic [167:0] exp);
    testCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Load result from the architectural rules, using plain arithmetic
  function automatic logic [31:0] loadValue(logic [4:0] op, logic [1:0] lo, logic [31:0] w);
    int unsigned b, h;
    b = (w >> (8 * int'(lo))) % 256;
    h = (w >> (16 * (int'(lo) / 2))) % 65536;
    case (op)
      5'b10000: return (b >= 128) ? b + 32'hFFFF_FF00 : b;
      5'b01000: return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      5'b00100: return w;
      5'b00010: return b;
      5'b00001: return h;
      default:  return 32'd0;
    endcase
  endfunction

  function automatic instr_t mkInstr(int kind, logic [4:0] op, logic [1:0] lo);
    instr_t i;
    i.reqSent = (kind != 0);
    i.ldOp    = (kind == 1) ? op : 5'd0;
    i.addrLo  = lo;
    i.rj      = $urandom;
    i.rkd     = $urandom;
    i.csr     = {3'b000, 31'($urandom)};
    i.grWe    = 1'($urandom);
    i.dest    = 5'($urandom);
    i.alu     = $urandom;
    i.pc      = $urandom;
    i.tag     = 0;
    return i;
  endfunction

  // Drive one cycle of inputs just after the clock edge, then check at the
  // falling edge. A new EXE instruction is only taken when EXE is empty.
  task automatic applyStimulus(input bit offer, input instr_t ins, input bit wsA,
                               input bit dOk, input logic [31:0] rd,
                               input bit ex, input bit ertn);
    if (offer && !exeValid) begin
      exeInstr     = ins;
      exeInstr.tag = nextTag++;
      exeValid     = 1'b1;
      if (ins.reqSent) reqQ.push_back('{exeInstr.tag, 1'b0});
    end
    esValid   = exeValid;
    esBus     = {exeInstr.reqSent, exeInstr.ldOp, exeInstr.addrLo, exeInstr.rj,
                 exeInstr.rkd, exeInstr.csr, exeInstr.grWe, exeInstr.dest,
                 exeInstr.alu, exeInstr.pc};
    wsAllowin = wsA;
    dataOk    = dOk;
    rdata     = rd;
    wbEx      = ex;
    wbErtn    = ertn;
    @(negedge clk);
    checkOutput();
  endtask

  task automatic checkOutput();
    bit          respMine, isLoad, blk;
    logic [31:0] word;
    respMine   = dataOk && reqQ.size() > 0 && !reqQ[0].killed;
    isLoad     = memInstr.ldOp != 5'd0;
    expReady   = !memInstr.reqSent || memHasData || respMine;
    expValid   = memValid && expReady;
    expAllowin = !memValid || (expReady && wsAllowin);
    word       = memHasData ? memData : rdata;
    expFinal   = isLoad ? loadValue(memInstr.ldOp, memInstr.addrLo, word) : memInstr.alu;
    blk        = memValid && ((isLoad && !expReady) || (memInstr.csr[33:31] != 3'b000));
    check("allowin", 168'(msAllowin), 168'(expAllowin));
    check("to_ws_valid", 168'(msToWsValid), 168'(expValid));
    if (expValid) begin
      check("to_ws_bus", msToWsBus,
            {memInstr.rj, memInstr.rkd, memInstr.csr, memInstr.grWe,
             memInstr.dest, expFinal, memInstr.pc});
    end
    if (memValid) begin
      check("fwd_bus", 168'(fwdBus),
            168'({1'b1, memInstr.grWe, memInstr.dest, expFinal, blk}));
    end else begin
      check("fwd_idle", 168'({fwdBus[39:38], fwdBus[0]}), 168'(0));
    end
  endtask

  // Apply the clock edge to the model, then move to just after the edge
  task automatic advance();
    req_t head;
    bit   leaving;
    leaving = expValid && wsAllowin;
    if (dataOk && reqQ.size() > 0) begin
      head = reqQ.pop_front();
      if (!head.killed && !leaving) begin
        memHasData = 1'b1;
        memData    = rdata;
      end
    end
    if (wbEx || wbErtn) begin
      memValid = 1'b0;
      exeValid = 1'b0;
      foreach (reqQ[i]) reqQ[i].killed = 1'b1;
    end else if (expAllowin) begin
      if (exeValid) begin
        memInstr   = exeInstr;
        memValid   = 1'b1;
        memHasData = 1'b0;
        exeValid   = 1'b0;
      end else begin
        memValid = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic step(input bit offer, input instr_t ins, input bit wsA, input bit dOk,
                      input logic [31:0] rd, input bit ex, input bit ertn);
    applyStimulus(offer, ins, wsA, dOk, rd, ex, ertn);
    advance();
  endtask

  // Reset both the DUT and the memory-side model
  task automatic doReset();
    reset = 1'b1; esValid = 1'b0; esBus = '0; wsAllowin = 1'b1;
    dataOk = 1'b0; rdata = '0; wbEx = 1'b0; wbErtn = 1'b0;
    exeValid = 1'b0; memValid = 1'b0; memHasData = 1'b0; memData = '0;
    memInstr = mkInstr(0, 5'd0, 2'd0);
    memInstr.rj = '0; memInstr.rkd = '0; memInstr.csr = '0; memInstr.grWe = 1'b0;
    memInstr.dest = '0; memInstr.alu = '0; memInstr.pc = '0;
    exeInstr = memInstr;
    reqQ.delete();
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_valid", 168'(msToWsValid), 168'(0));
    check("rst_allowin", 168'(msAllowin), 168'(1));
    check("rst_fwd", 168'(fwdBus), 168'(0));
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    instr_t ins;
    bit offer, wsA, dOk, fl, legal;
    int kind;

    idle = mkInstr(0, 5'd0, 2'd0);
    doReset();

    // ld.b from byte 3, data in the entry cycle
    step(1, mkInstr(1, 5'b10000, 2'd3), 1, 0, $urandom, 0, 0);
    applyStimulus(0, idle, 1, 1, 32'h80FF_1234, 0, 0);
    check("ldb_valid", 168'(msToWsValid), 168'(1));
    check("ldb_result", 168'(msToWsBus[63:32]), 168'(32'hFFFF_FF80));
    advance();
    step(0, idle, 1, 0, $urandom, 0, 0);

    // ld.hu from half 2, data three cycles late
    step(1, mkInstr(1, 5'b00001, 2'd2), 1, 0, $urandom, 0, 0);
    repeat (3) begin
      applyStimulus(0, idle, 1, 0, $urandom, 0, 0);
      check("ldhu_wait_valid", 168'(msToWsValid), 168'(0));
      check("ldhu_wait_blk", 168'(fwdBus[0]), 168'(1));
      advance();
    end
    applyStimulus(0, idle, 1, 1, 32'hBEEF_0000, 0, 0);
    check("ldhu_valid", 168'(msToWsValid), 168'(1));
    check("ldhu_result", 168'(msToWsBus[63:32]), 168'(32'h0000_BEEF));
    advance();

    // ld.w answered while WB stalls, delivered from the buffer later
    step(1, mkInstr(1, 5'b00100, 2'd0), 1, 0, $urandom, 0, 0);
    step(0, idle, 0, 1, 32'h1234_5678, 0, 0);
    step(0, idle, 0, 0, $urandom, 0, 0);
    applyStimulus(0, idle, 1, 0, $urandom, 0, 0);
    check("buf_valid", 168'(msToWsValid), 168'(1));
    check("buf_result", 168'(msToWsBus[63:32]), 168'(32'h1234_5678));
    advance();

    // Flush with a waiting MEM load and a sent EXE load: two drops follow
    step(1, mkInstr(1, 5'b00100, 2'd0), 1, 0, $urandom, 0, 0);
    step(1, mkInstr(1, 5'b00100, 2'd0), 1, 0, $urandom, 0, 0);
    step(0, idle, 1, 0, $urandom, 1, 0);
    check("flush_gone", 168'(fwdBus[39]), 168'(0));
    step(1, mkInstr(1, 5'b00100, 2'd0), 1, 0, $urandom, 0, 0);
    repeat (2) begin
      applyStimulus(0, idle, 1, 1, $urandom, 0, 0);
      check("flush_drop", 168'(msToWsValid), 168'(0));
      advance();
    end
    applyStimulus(0, idle, 1, 1, 32'hCAFE_F00D, 0, 0);
    check("flush_third", 168'(msToWsValid), 168'(1));
    check("flush_third_res", 168'(msToWsBus[63:32]), 168'(32'hCAFE_F00D));
    advance();

    // Back-to-back ALU instructions, one per cycle
    for (int i = 0; i < 4; i++) begin
      ins = mkInstr(0, 5'd0, 2'd0);
      applyStimulus(1, ins, 1, 0, $urandom, 0, 0);
      if (i > 0) check("alu_stream", 168'(msToWsValid), 168'(1));
      advance();
    end
    step(0, idle, 1, 0, $urandom, 0, 0);

    // Reset while one dropped response is still owed
    step(1, mkInstr(1, 5'b00100, 2'd0), 1, 0, $urandom, 0, 0);
    step(0, idle, 1, 0, $urandom, 0, 1);
    doReset();
    step(1, mkInstr(1, 5'b00100, 2'd0), 1, 0, $urandom, 0, 0);
    applyStimulus(0, idle, 1, 1, 32'h0BAD_BEEF, 0, 0);
    check("post_rst_valid", 168'(msToWsValid), 168'(1));
    advance();

    // Random traffic against the model
    for (int c = 0; c < 600; c++) begin
      kind  = $urandom_range(0, 2);
      if (kind != 0 && reqQ.size() > 1) kind = 0;
      ins   = mkInstr(kind, 5'b00001 << $urandom_range(0, 4), 2'($urandom));
      if (kind == 0 && $urandom_range(0, 9) == 0)
        ins.csr[33:31] = 3'b001 << $urandom_range(0, 2);
      offer = $urandom_range(0, 99) < 60;
      wsA   = $urandom_range(0, 99) < 70;
      fl    = $urandom_range(0, 99) < 6;
      legal = reqQ.size() > 0 &&
              (reqQ[0].killed || (memValid && !memHasData && memInstr.tag == reqQ[0].id));
      dOk   = legal && ($urandom_range(0, 99) < 45);
      step(offer, ins, wsA, dOk, $urandom, fl && $urandom_range(0, 1) == 0,
           fl && $urandom_range(0, 1) == 1);
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
